// File: rtl/pipe_reg_chain_pkg.sv
// -----------------------------------------------------------------------------
// pipe_reg_chain_pkg
// Shared definitions for the pipeline register chain and its stage register.
//   PIPE_MAX_DEPTH     : largest supported number of stages
//   PIPE_NOP           : NOP instruction encoding, the usual RESET_VALUE for
//                        instruction-carrying stages
//   pipe_count_width() : width of the occupancy counter for a given depth
// -----------------------------------------------------------------------------
package pipe_reg_chain_pkg;

    localparam int PIPE_MAX_DEPTH = 8;

    localparam logic [31:0] PIPE_NOP = 32'h0000_0000;

    // Bits needed to hold the values 0..depth inclusive.
    function automatic int pipe_count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage : pipe_reg_chain_pkg

// File: rtl/pipe_reg_chain_stage.sv
// -----------------------------------------------------------------------------
// pipe_reg_chain_stage
// One valid + data register of the pipeline chain with valid/ready handshake.
// Ports:
//   clk, reset  : rising-edge clock, asynchronous active-high reset
//   flush       : synchronous squash (clears valid, optionally data)
//   prev_v/d    : valid/data offered by the upstream stage (or chain input)
//   next_rdy    : ready of the downstream stage (or chain out_ready)
//   v, d        : registered valid/data held by this stage
//   rdy         : this stage can take a new word this cycle
// -----------------------------------------------------------------------------
module pipe_reg_chain_stage
    import pipe_reg_chain_pkg::*;
#(
    parameter int               WIDTH          = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE    = PIPE_NOP[WIDTH-1:0],
    parameter bit               CLEAR_ON_FLUSH = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             prev_v,
    input  logic [WIDTH-1:0] prev_d,
    input  logic             next_rdy,
    output logic             v,
    output logic [WIDTH-1:0] d,
    output logic             rdy
);

    logic             v_q;
    logic             v_d;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] d_d;

    // Ready: an empty stage always accepts; a full one only if it can move on.
    always_comb begin
        rdy = !v_q | next_rdy;
    end

    // Next-state: flush beats load, load beats hold; bubbles never touch data.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (flush) begin
            v_d = 1'b0;
            if (CLEAR_ON_FLUSH) begin
                d_d = RESET_VALUE;
            end else begin
                d_d = d_q;
            end
        end else if (rdy) begin
            v_d = prev_v;
            if (prev_v) begin
                d_d = prev_d;
            end else begin
                d_d = d_q;
            end
        end else begin
            v_d = v_q;
            d_d = d_q;
        end
    end

    // Stage register with asynchronous reset to the empty state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q <= 1'b0;
            d_q <= RESET_VALUE;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign v = v_q;
    assign d = d_q;

endmodule : pipe_reg_chain_stage

// File: rtl/pipe_reg_chain.sv
// -----------------------------------------------------------------------------
// pipe_reg_chain
// Chain of DEPTH valid/ready pipeline registers with bubble compression,
// synchronous flush and a registered occupancy count.
// Ports:
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   flush               : synchronous squash of every stage
//   in_valid/in_data    : upstream word; in_ready says stage 0 accepts it
//   out_valid/out_data  : word held in the last stage; out_ready from downstream
//   count               : number of stages currently holding valid data
// -----------------------------------------------------------------------------
module pipe_reg_chain
    import pipe_reg_chain_pkg::*;
#(
    parameter int               WIDTH          = 32,
    parameter int               DEPTH          = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE    = PIPE_NOP[WIDTH-1:0],
    parameter bit               CLEAR_ON_FLUSH = 1'b1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 flush,
    input  logic                                 in_valid,
    input  logic [WIDTH-1:0]                     in_data,
    output logic                                 in_ready,
    output logic                                 out_valid,
    output logic [WIDTH-1:0]                     out_data,
    input  logic                                 out_ready,
    output logic [pipe_count_width(DEPTH)-1:0]   count
);

    localparam int CW = pipe_count_width(DEPTH);

    if ((DEPTH < 1) || (DEPTH > PIPE_MAX_DEPTH)) begin : g_bad_depth
        $error("pipe_reg_chain: DEPTH %0d outside 1..%0d", DEPTH, PIPE_MAX_DEPTH);
    end

    // rdy_s[DEPTH] is the downstream ready; rdy_s[i] ripples back through
    // every stage in the same cycle so a full chain still streams.
    logic [DEPTH:0]   rdy_s;
    logic [DEPTH-1:0] v_s;
    logic [DEPTH-1:0] prev_v_s;
    logic [WIDTH-1:0] d_s      [DEPTH];
    logic [WIDTH-1:0] prev_d_s [DEPTH];

    logic             in_xfer_s;
    logic             out_xfer_s;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    assign rdy_s[DEPTH] = out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign prev_v_s[i] = in_valid;
            assign prev_d_s[i] = in_data;
        end else begin : g_body
            assign prev_v_s[i] = v_s[i-1];
            assign prev_d_s[i] = d_s[i-1];
        end

        pipe_reg_chain_stage #(
            .WIDTH          (WIDTH),
            .RESET_VALUE    (RESET_VALUE),
            .CLEAR_ON_FLUSH (CLEAR_ON_FLUSH)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush),
            .prev_v   (prev_v_s[i]),
            .prev_d   (prev_d_s[i]),
            .next_rdy (rdy_s[i+1]),
            .v        (v_s[i]),
            .d        (d_s[i]),
            .rdy      (rdy_s[i])
        );
    end

    // Handshake outputs; in_ready is masked so a flushed cycle accepts nothing.
    always_comb begin
        in_ready   = rdy_s[0] & !flush;
        out_valid  = v_s[DEPTH-1];
        out_data   = d_s[DEPTH-1];
        in_xfer_s  = in_valid & in_ready;
        out_xfer_s = out_valid & out_ready;
    end

    // Occupancy tracks popcount(v): bubble moves inside the chain never
    // change it, only boundary transfers do, and flush empties everything.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = {CW{1'b0}};
        end else begin
            count_d = count_q + CW'(in_xfer_s) - CW'(out_xfer_s);
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : pipe_reg_chain

// File: tb/tb_pipe_reg_chain.sv
module tb_pipe_reg_chain;
    import pipe_reg_chain_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 3;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [CW-1:0]    count;

    int checks = 0;
    int errors = 0;

    pipe_reg_chain #(
        .WIDTH          (WIDTH),
        .DEPTH          (DEPTH),
        .RESET_VALUE    (PIPE_NOP),
        .CLEAR_ON_FLUSH (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then driven 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [31:0] d);
        in_valid = v;
        in_data  = d;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data",  out_data,       32'h0);
        chk("rst_count",     32'(count),     32'h0);
        chk("rst_in_ready",  32'(in_ready),  32'h1);
        reset = 1'b0;
        tick();

        // Streaming: words 1..4 back-to-back, out on cycles 3..6.
        for (int c = 1; c <= 7; c++) begin
            drive(c <= 4, 32'(c));
            tick();
            if (c >= 3 && c <= 6) begin
                chk("stream_valid", 32'(out_valid), 32'h1);
                chk("stream_data",  out_data,       32'(c - 2));
            end else begin
                chk("stream_idle",  32'(out_valid), 32'h0);
            end
            chk("stream_count", 32'(count), (c <= 3) ? 32'(c) : 32'(7 - c));
        end

        // Backpressure: fill with A,B,C; D stalls.
        out_ready = 1'b0;
        drive(1'b1, 32'hA);
        #1 chk("bp_ready_empty", 32'(in_ready), 32'h1);
        tick();
        drive(1'b1, 32'hB); tick();
        drive(1'b1, 32'hC); tick();
        chk("bp_count_full", 32'(count), 32'h3);
        drive(1'b1, 32'hD);
        #1 chk("bp_ready_full", 32'(in_ready), 32'h0);
        tick();
        chk("bp_stall_count", 32'(count),    32'h3);
        chk("bp_head_data",   out_data,      32'hA);
        chk("bp_still_stall", 32'(in_ready), 32'h0);
        out_ready = 1'b1;
        #1 chk("bp_ready_ripple", 32'(in_ready), 32'h1);
        tick();
        chk("bp_out_b", out_data, 32'hB);
        drive(1'b0, 32'h0);
        tick();
        chk("bp_out_c", out_data, 32'hC);
        tick();
        chk("bp_out_d",       out_data,       32'hD);
        chk("bp_out_d_valid", 32'(out_valid), 32'h1);
        tick();
        chk("bp_drained", 32'(out_valid), 32'h0);
        chk("bp_count0",  32'(count),     32'h0);

        // Bubble compression: 0x11, idle, 0x22 with downstream stalled.
        out_ready = 1'b0;
        drive(1'b1, 32'h11); tick();
        drive(1'b0, 32'h0);  tick();
        drive(1'b1, 32'h22); tick();
        chk("bub_count3",   32'(count),     32'h2);
        chk("bub_out_data", out_data,       32'h11);
        chk("bub_out_val",  32'(out_valid), 32'h1);
        drive(1'b0, 32'h0);  tick();
        chk("bub_count4",   32'(count),     32'h2);
        chk("bub_in_ready", 32'(in_ready),  32'h1);
        out_ready = 1'b1;
        tick();
        chk("bub_out_22", out_data, 32'h22);
        tick();
        chk("bub_empty",     32'(out_valid), 32'h0);
        chk("bub_data_held", out_data,       32'h22);

        // Flush with two valid stages and an offered word 0x55.
        out_ready = 1'b0;
        drive(1'b1, 32'h31); tick();
        drive(1'b1, 32'h32); tick();
        drive(1'b0, 32'h0);  tick();
        chk("fl_pre_count", 32'(count), 32'h2);
        chk("fl_pre_data",  out_data,   32'h31);
        flush     = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'h55);
        #1 chk("fl_in_ready",  32'(in_ready),  32'h0);
        chk("fl_out_valid_kept", 32'(out_valid), 32'h1);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0);
        chk("fl_count",     32'(count),     32'h0);
        chk("fl_out_valid", 32'(out_valid), 32'h0);
        chk("fl_out_data",  out_data,       32'h0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("fl_no_55", 32'(out_valid), 32'h0);
        end

        // Full-chain pass-through: simultaneous in and out for 4 cycles.
        out_ready = 1'b0;
        drive(1'b1, 32'h61); tick();
        drive(1'b1, 32'h62); tick();
        drive(1'b1, 32'h63); tick();
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 32'(32'h64 + c));
            #1 chk("pt_in_ready", 32'(in_ready), 32'h1);
            tick();
            chk("pt_out_data", out_data,   32'(32'h62 + c));
            chk("pt_count",    32'(count), 32'h3);
        end
        drive(1'b0, 32'h0);
        tick();
        chk("pt_out_66", out_data, 32'h66);
        tick();
        chk("pt_out_67", out_data, 32'h67);
        tick();
        chk("pt_empty", 32'(out_valid), 32'h0);

        // Asynchronous reset mid-stream with two valid stages.
        out_ready = 1'b0;
        drive(1'b1, 32'h71); tick();
        drive(1'b1, 32'h72); tick();
        drive(1'b0, 32'h0);  tick();
        chk("ar_pre_valid", 32'(out_valid), 32'h1);
        chk("ar_pre_count", 32'(count),     32'h2);
        #1 reset = 1'b1;
        #1;
        chk("ar_out_valid", 32'(out_valid), 32'h0);
        chk("ar_out_data",  out_data,       32'h0);
        chk("ar_count",     32'(count),     32'h0);
        chk("ar_in_ready",  32'(in_ready),  32'h1);
        reset = 1'b0;
        tick();
        chk("ar_post_count", 32'(count),     32'h0);
        chk("ar_post_valid", 32'(out_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pipe_reg_chain
